// File: rtl/genome_pkg.sv
// Shared constants for genome loading and logic-element gene decoding.
package genome_pkg;

  localparam int unsigned GENE_W = 13;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned FUNC_W = 3;

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RSVD  = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_CSUM  = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LO     = 3'd1,
    S_HI     = 3'd2,
    S_CHK    = 3'd3,
    S_COMMIT = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/genome_gene_check.sv
// Assembles one gene from its LO/HI bytes and flags reserved-bit and select-range faults.
module genome_gene_check
  import genome_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 27
) (
  input  logic [7:0]        lo_byte,
  input  logic [7:0]        hi_byte,
  output logic [GENE_W-1:0] gene,
  output logic              rsvd_err,
  output logic              range_err
);

  localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_INPUTS);

  logic [9:0]       conf_ins;
  logic [FUNC_W-1:0] conf_func;
  logic [SEL_W-1:0] sel0;
  logic [SEL_W-1:0] sel1;

  // Split the byte pair into function, selects and validity flags.
  always_comb begin
    conf_ins  = {hi_byte[1:0], lo_byte};
    conf_func = hi_byte[4:2];
    sel0      = conf_ins[SEL_W-1:0];
    sel1      = conf_ins[2*SEL_W-1:SEL_W];
    gene      = {conf_func, conf_ins};
    rsvd_err  = |hi_byte[7:5];
    range_err = ({1'b0, sel0} >= LIMIT) || ({1'b0, sel1} >= LIMIT);
  end

endmodule

// File: rtl/genome_loader.sv
// Receives a header-framed genome byte stream, validates and checksums it into a
// shadow bank, and commits it atomically to the active configuration bus.
module genome_loader
  import genome_pkg::*;
#(
  parameter int unsigned NUM_LE     = 16,
  parameter int unsigned NUM_INPUTS = 27,
  parameter logic [7:0]  HEADER     = genome_pkg::HEADER
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [NUM_LE*GENE_W-1:0] cfg_bus,
  output logic                     cfg_commit,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               err_code
);

  localparam int unsigned IDX_W = (NUM_LE > 1) ? $clog2(NUM_LE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LE - 1);

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [7:0]                 csum;
  logic [7:0]                 lo_byte;
  logic [NUM_LE*GENE_W-1:0]   shadow;
  logic                       ready_en;
  err_code_t                  err_code_q;

  logic [GENE_W-1:0]          gene;
  logic                       rsvd_err;
  logic                       range_err;
  logic                       take;

  genome_gene_check #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_gene_check (
    .lo_byte  (lo_byte),
    .hi_byte  (rx_data),
    .gene     (gene),
    .rsvd_err (rsvd_err),
    .range_err(range_err)
  );

  // ready_en holds rx_ready low through reset; after that it depends on state only.
  always_comb begin
    rx_ready = ready_en && (state != S_COMMIT) && (state != S_ERROR);
    take     = rx_valid && rx_ready;
    err_code = err_code_q;
  end

  // Load FSM; commit/err pulses are raised on entry so they coincide with the
  // one-cycle COMMIT/ERROR states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      csum       <= '0;
      lo_byte    <= '0;
      shadow     <= '0;
      cfg_bus    <= '0;
      cfg_commit <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
      ready_en   <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      cfg_commit <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take && (rx_data == HEADER)) begin
            state <= S_LO;
            idx   <= '0;
            csum  <= '0;
            busy  <= 1'b1;
          end
        end
        S_LO: begin
          if (take) begin
            lo_byte <= rx_data;
            csum    <= csum ^ rx_data;
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (take) begin
            csum <= csum ^ rx_data;
            if (rsvd_err || range_err) begin
              state      <= S_ERROR;
              err        <= 1'b1;
              err_code_q <= rsvd_err ? ERR_RSVD : ERR_RANGE;
              busy       <= 1'b0;
              shadow     <= '0;
            end else begin
              shadow[idx*GENE_W +: GENE_W] <= gene;
              if (idx == LAST_IDX) begin
                state <= S_CHK;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_LO;
              end
            end
          end
        end
        S_CHK: begin
          if (take) begin
            if (rx_data == csum) begin
              state      <= S_COMMIT;
              cfg_bus    <= shadow;
              cfg_commit <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state      <= S_ERROR;
              err        <= 1'b1;
              err_code_q <= ERR_CSUM;
              busy       <= 1'b0;
              shadow     <= '0;
            end
          end
        end
        S_COMMIT: state <= S_IDLE;
        S_ERROR:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_genome_loader.sv
// Directed self-checking bench for genome_loader.
module tb_genome_loader;
  import genome_pkg::*;

  localparam int NUM_LE = 16;
  localparam int BUS_W  = NUM_LE * 13;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             rx_ready;
  logic [BUS_W-1:0] cfg_bus;
  logic             cfg_commit;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0]       lo_b [NUM_LE];
  logic [7:0]       hi_b [NUM_LE];
  logic [BUS_W-1:0] bus1, bus2, bus3;

  int commit_cnt = 0, err_cnt = 0, busy_acc = 0, ready_low_cnt = 0, commit_low_cnt = 0;
  bit mon_ready = 1'b0;

  always #5 clk = ~clk;

  genome_loader #(
    .NUM_LE(16),
    .NUM_INPUTS(27),
    .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cfg_bus(cfg_bus), .cfg_commit(cfg_commit), .busy(busy), .err(err), .err_code(err_code)
  );

  always @(negedge clk) begin
    if (cfg_commit) commit_cnt++;
    if (err) err_cnt++;
    if (rx_valid && rx_ready && busy) busy_acc++;
    if (mon_ready && !rx_ready) begin
      ready_low_cnt++;
      if (cfg_commit) commit_low_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after gap idle cycles; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    logic acc;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    do begin
      acc = rx_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout byte %h never accepted", b);
    end
  endtask

  task automatic send_genome(input logic [7:0] cs, input int gmax);
    send(8'hA5, (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
    for (int k = 0; k < NUM_LE; k++) begin
      send(lo_b[k], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
      send(hi_b[k], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
    end
    send(cs, (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
  endtask

  task automatic load_g1();
    for (int k = 0; k < NUM_LE; k++) begin
      lo_b[k] = 8'(k);
      hi_b[k] = 8'h04;
    end
  endtask

  task automatic load_g2();
    for (int k = 0; k < NUM_LE; k++) begin
      lo_b[k] = 8'(k + 1);
      hi_b[k] = 8'h0A;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (cfg_bus !== '0) begin errors++; $display("FAIL reset_bus got %h exp 0", cfg_bus); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rx_ready); end
    checks++; if ({busy, err, cfg_commit} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, err, cfg_commit}); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
    rst = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL ready_release_same got %b exp 0", rx_ready); end
    tick();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b exp 1", rx_ready); end
  endtask

  task automatic test_basic();
    int c0, b0;
    load_g1();
    c0 = commit_cnt;
    b0 = busy_acc;
    send_genome(8'h00, 0);  // XOR(0..15)=0, sixteen 0x04 cancel
    checks++; if (cfg_commit !== 1'b1) begin errors++; $display("FAIL basic_commit got %b exp 1", cfg_commit); end
    checks++; if (cfg_bus !== bus1) begin errors++; $display("FAIL basic_bus got %h exp %h", cfg_bus, bus1); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_commit got %b exp 0", rx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_commit got %b exp 0", busy); end
    tick();
    checks++; if ({cfg_commit, rx_ready} !== 2'b01) begin errors++; $display("FAIL basic_after got %b exp 01", {cfg_commit, rx_ready}); end
    checks++; if (commit_cnt - c0 !== 1) begin errors++; $display("FAIL basic_commit_count got %0d exp 1", commit_cnt - c0); end
    checks++; if (busy_acc - b0 !== 33) begin errors++; $display("FAIL basic_busy_accepts got %0d exp 33", busy_acc - b0); end
  endtask

  task automatic test_idle_drop();
    int e0;
    e0 = err_cnt;
    send(8'h00, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy_00 got %b exp 0", busy); end
    send(8'h5A, 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy_5a got %b exp 0", busy); end
    tick();
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL idle_err got %0d exp 0", err_cnt - e0); end
    load_g2();
    send_genome(8'h10, 0);  // XOR(1..16)=0x10, sixteen 0x0A cancel
    checks++; if (cfg_commit !== 1'b1) begin errors++; $display("FAIL idle_commit got %b exp 1", cfg_commit); end
    checks++; if (cfg_bus !== bus2) begin errors++; $display("FAIL idle_bus got %h exp %h", cfg_bus, bus2); end
    tick();
  endtask

  task automatic test_bad_csum();
    load_g1();
    send_genome(8'h55, 0);
    checks++; if ({err, cfg_commit} !== 2'b10) begin errors++; $display("FAIL csum_pulse got %b exp 10", {err, cfg_commit}); end
    checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL csum_code got %0d exp 3", err_code); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL csum_ready got %b exp 0", rx_ready); end
    checks++; if (cfg_bus !== bus2) begin errors++; $display("FAIL csum_bus got %h exp %h", cfg_bus, bus2); end
    tick();
    checks++; if ({err, err_code} !== 3'b011) begin errors++; $display("FAIL csum_hold got %b exp 011", {err, err_code}); end
  endtask

  task automatic test_select_errors();
    logic [7:0] lo3 [4];
    logic [7:0] hi3 [4];
    logic [1:0] code [4];
    int e0;
    lo3[0] = 8'h1B; hi3[0] = 8'h04; code[0] = 2'd2;  // sel0 = 27
    lo3[1] = 8'h03; hi3[1] = 8'h20; code[1] = 2'd1;  // reserved bit
    lo3[2] = 8'h1B; hi3[2] = 8'h20; code[2] = 2'd1;  // both: reserved wins
    lo3[3] = 8'h60; hi3[3] = 8'h07; code[3] = 2'd2;  // sel1 = 27
    load_g1();
    for (int c = 0; c < 4; c++) begin
      e0 = err_cnt;
      send(8'hA5, 0);
      for (int k = 0; k < 3; k++) begin
        send(lo_b[k], 0);
        send(hi_b[k], 0);
      end
      send(lo3[c], 0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL sel_early_err case %0d got %b exp 0", c, err); end
      send(hi3[c], 0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL sel_err case %0d got %b exp 1", c, err); end
      checks++; if (err_code !== code[c]) begin errors++; $display("FAIL sel_code case %0d got %0d exp %0d", c, err_code, code[c]); end
      checks++; if (cfg_bus !== bus2) begin errors++; $display("FAIL sel_bus case %0d got %h exp %h", c, cfg_bus, bus2); end
      tick();
      checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL sel_err_count case %0d got %0d exp 1", c, err_cnt - e0); end
    end
    // Both selects at 26 are in range and must commit.
    lo_b[3] = 8'h5A;
    hi_b[3] = 8'h07;
    send_genome(8'h5A, 0);  // 0 ^ 03 ^ 04 ^ 5A ^ 07
    checks++; if (cfg_commit !== 1'b1) begin errors++; $display("FAIL sel_edge_commit got %b exp 1", cfg_commit); end
    checks++; if (cfg_bus !== bus3) begin errors++; $display("FAIL sel_edge_bus got %h exp %h", cfg_bus, bus3); end
    tick();
  endtask

  task automatic test_reset_mid();
    int e0;
    load_g1();
    e0 = err_cnt;
    send(8'hA5, 0);
    for (int k = 0; k < 3; k++) begin
      send(lo_b[k], 0);
      send(hi_b[k], 0);
    end
    send(lo_b[3], 0);
    rst = 1'b1;
    tick();
    checks++; if (cfg_bus !== '0) begin errors++; $display("FAIL midrst_bus got %h exp 0", cfg_bus); end
    checks++; if ({busy, rx_ready} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b exp 00", {busy, rx_ready}); end
    rst = 1'b0;
    tick();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", rx_ready); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_err got %0d exp 0", err_cnt - e0); end
    load_g2();
    send_genome(8'h10, 0);
    checks++; if (cfg_commit !== 1'b1) begin errors++; $display("FAIL midrst_commit got %b exp 1", cfg_commit); end
    checks++; if (cfg_bus !== bus2) begin errors++; $display("FAIL midrst_bus2 got %h exp %h", cfg_bus, bus2); end
    tick();
  endtask

  task automatic test_gaps();
    int c0, r0, cl0, e0;
    load_g1();
    c0  = commit_cnt;
    r0  = ready_low_cnt;
    cl0 = commit_low_cnt;
    e0  = err_cnt;
    mon_ready = 1'b1;
    send_genome(8'h00, 5);
    checks++; if (cfg_bus !== bus1) begin errors++; $display("FAIL gaps_bus got %h exp %h", cfg_bus, bus1); end
    repeat (3) tick();
    mon_ready = 1'b0;
    checks++; if (commit_cnt - c0 !== 1) begin errors++; $display("FAIL gaps_commit got %0d exp 1", commit_cnt - c0); end
    checks++; if (ready_low_cnt - r0 !== 1) begin errors++; $display("FAIL gaps_ready_low got %0d exp 1", ready_low_cnt - r0); end
    checks++; if (commit_low_cnt - cl0 !== 1) begin errors++; $display("FAIL gaps_ready_low_commit got %0d exp 1", commit_low_cnt - cl0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL gaps_err got %0d exp 0", err_cnt - e0); end
  endtask

  initial begin
    for (int k = 0; k < NUM_LE; k++) begin
      bus1[k*13 +: 13] = {3'd1, 10'(k)};
      bus2[k*13 +: 13] = {3'd2, 2'd2, 8'(k + 1)};
    end
    bus3 = bus1;
    bus3[3*13 +: 13] = {3'd1, 2'd3, 8'h5A};

    test_reset();
    test_basic();
    test_idle_drop();
    test_bad_csum();
    test_select_errors();
    test_reset_mid();
    test_gaps();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
